// File: rtl/controle_multiciclo.sv
// Multi-cycle sequencer: walks the datapath through fetch/decode/execute/memory/writeback,
// handling memory wait states with a timeout and trapping on illegal instructions.
module controle_multiciclo #(
  parameter logic [6:0] R_TYPE      = 7'b0110011,
  parameter logic [6:0] ARITMETIC_I = 7'b0010011,
  parameter logic [6:0] LOAD_TYPE   = 7'b0000011,
  parameter logic [6:0] STORE_TYPE  = 7'b0100011,
  parameter logic [6:0] SUBI        = 7'b0011111,
  parameter int         TIMEOUT     = 15,
  parameter int         COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            instrucao,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   addr_sel,
  output logic                   ir_en,
  output logic                   pc_en,
  output logic                   reg_we,
  output logic [1:0]             op_ula,
  output logic                   ula_entry,
  output logic                   operation_type,
  output logic                   busy,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [COUNT_WIDTH-1:0] instret,
  output logic [2:0]             estado
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                         S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_TRAP = 3'd7;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]             state_q, state_d;
  logic [1:0]             op_ula_q, op_ula_d;
  logic                   ula_entry_q, ula_entry_d;
  logic                   op_type_q, op_type_d;
  logic                   is_load_q, is_load_d;
  logic                   is_store_q, is_store_d;
  logic [7:0]             wait_q, wait_d;
  logic [1:0]             cause_q, cause_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       dec_ok, dec_ue, dec_ot, dec_ld, dec_st;
  logic [1:0] dec_op;

  assign opcode = instrucao[6:0];
  assign funct3 = instrucao[14:12];
  assign funct7 = instrucao[31:25];

  always_comb begin
    dec_ok = 1'b0;
    dec_op = op_ula_q;
    dec_ue = ula_entry_q;
    dec_ot = op_type_q;
    dec_ld = 1'b0;
    dec_st = 1'b0;
    case (opcode)
      R_TYPE: begin
        dec_ue = 1'b1;
        dec_ot = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin dec_op = 2'b01; dec_ok = 1'b1; end
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin dec_op = 2'b00; dec_ok = 1'b1; end
        else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin dec_op = 2'b11; dec_ok = 1'b1; end
      end
      ARITMETIC_I: begin
        dec_ue = 1'b0;
        dec_ot = 1'b1;
        if (funct3 == 3'b000) begin dec_op = 2'b01; dec_ok = 1'b1; end
        else if (funct3 == 3'b010) begin dec_op = 2'b11; dec_ok = 1'b1; end
      end
      LOAD_TYPE:  begin dec_op = 2'b01; dec_ue = 1'b0; dec_ot = 1'b0; dec_ld = 1'b1; dec_ok = 1'b1; end
      STORE_TYPE: begin dec_op = 2'b01; dec_ue = 1'b0; dec_ot = 1'b0; dec_st = 1'b1; dec_ok = 1'b1; end
      SUBI:       begin dec_op = 2'b00; dec_ue = 1'b0; dec_ot = 1'b1; dec_ok = 1'b1; end
      default:    dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_ula_d    = op_ula_q;
    ula_entry_d = ula_entry_q;
    op_type_d   = op_type_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    wait_d      = wait_q;
    cause_d     = cause_q;
    instret_d   = instret_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    reg_we      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin state_d = S_FETCH; wait_d = 8'd0; end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (wait_q == TMO) begin state_d = S_TRAP; cause_d = 2'b10; end
        else wait_d = wait_q + 8'd1;
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_d     = S_EXECUTE;
          op_ula_d    = dec_op;
          ula_entry_d = dec_ue;
          op_type_d   = dec_ot;
          is_load_d   = dec_ld;
          is_store_d  = dec_st;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXECUTE: begin
        if (is_load_q || is_store_q) begin state_d = S_MEMORY; wait_d = 8'd0; end
        else state_d = S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store_q;
        if (mem_ready) begin
          if (is_store_q) begin
            // A store retires here; it has nothing to write back.
            pc_en     = 1'b1;
            instret_d = instret_q + ONE;
            state_d   = S_FETCH;
            wait_d    = 8'd0;
          end else state_d = S_WRITEBACK;
        end else if (wait_q == TMO) begin state_d = S_TRAP; cause_d = 2'b10; end
        else wait_d = wait_q + 8'd1;
      end
      S_WRITEBACK: begin
        reg_we    = 1'b1;
        pc_en     = 1'b1;
        instret_d = instret_q + ONE;
        state_d   = S_FETCH;
        wait_d    = 8'd0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_ula_q    <= 2'b00;
      ula_entry_q <= 1'b0;
      op_type_q   <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      wait_q      <= 8'd0;
      cause_q     <= 2'b00;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_ula_q    <= op_ula_d;
      ula_entry_q <= ula_entry_d;
      op_type_q   <= op_type_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      wait_q      <= wait_d;
      cause_q     <= cause_d;
      instret_q   <= instret_d;
    end
  end

  assign op_ula         = op_ula_q;
  assign ula_entry      = ula_entry_q;
  assign operation_type = op_type_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap           = (state_q == S_TRAP);
  assign trap_cause     = cause_q;
  assign instret        = instret_q;
  assign estado         = state_q;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations, a negedge monitor compares.
module tb_controle_multiciclo;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1, start = 1'b0, mem_ready = 1'b0;
  logic [31:0] instrucao = 32'h0;

  logic mr0, mw0, as0, ie0, pe0, rw0, ue0, ot0, bz0, tp0;
  logic [1:0] op0, tc0;
  logic [2:0] st0;
  logic [31:0] ir0;
  logic mr1, mw1, as1, ie1, pe1, rw1, ue1, ot1, bz1, tp1;
  logic [1:0] op1, tc1;
  logic [2:0] st1;
  logic [3:0] ir1;

  controle_multiciclo dut0 (
    .clock(clock), .reset(reset), .start(start), .instrucao(instrucao), .mem_ready(mem_ready),
    .mem_req(mr0), .mem_we(mw0), .addr_sel(as0), .ir_en(ie0), .pc_en(pe0), .reg_we(rw0),
    .op_ula(op0), .ula_entry(ue0), .operation_type(ot0), .busy(bz0), .trap(tp0),
    .trap_cause(tc0), .instret(ir0), .estado(st0));

  controle_multiciclo #(.TIMEOUT(2), .COUNT_WIDTH(4)) dut1 (
    .clock(clock), .reset(reset), .start(start), .instrucao(instrucao), .mem_ready(mem_ready),
    .mem_req(mr1), .mem_we(mw1), .addr_sel(as1), .ir_en(ie1), .pc_en(pe1), .reg_we(rw1),
    .op_ula(op1), .ula_entry(ue1), .operation_type(ot1), .busy(bz1), .trap(tp1),
    .trap_cause(tc1), .instret(ir1), .estado(st1));

  typedef struct {
    logic [16:0] s;
    logic [31:0] n;
    string       nm;
  } exp_t;

  exp_t q[$];
  int vecs = 0, miss = 0;
  logic sel = 1'b0;
  logic [16:0] act_s;
  logic [31:0] act_n;
  logic [31:0] ninst = 0, mask = 32'hFFFF_FFFF;
  logic [3:0] pctl = 4'b0000;

  // {req,we,asel,ir_en,pc_en,reg_we, op_ula,ula_entry,op_type, busy,trap, cause, estado}
  always_comb begin
    if (sel) begin
      act_s = {mr1, mw1, as1, ie1, pe1, rw1, op1, ue1, ot1, bz1, tp1, tc1, st1};
      act_n = {28'h0, ir1};
    end else begin
      act_s = {mr0, mw0, as0, ie0, pe0, rw0, op0, ue0, ot0, bz0, tp0, tc0, st0};
      act_n = ir0;
    end
  end

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      if (act_s !== e.s || act_n !== e.n) begin
        miss++;
        $display("FAIL %s: got sig=%05h instret=%0d, want sig=%05h instret=%0d",
                 e.nm, act_s, act_n, e.s, e.n);
      end
    end
  end

  function automatic logic [16:0] ex(input logic [2:0] st, input logic [5:0] strb,
                                     input logic [3:0] ctl, input logic [1:0] tc);
    return {strb, ctl, (st != 3'd0 && st != 3'd7), (st == 3'd7), tc, st};
  endfunction

  task automatic cyc(input logic rst, input logic st, input logic rdy, input logic chk,
                     input logic [16:0] s, input string nm);
    exp_t e;
    reset = rst; start = st; mem_ready = rdy;
    if (chk) begin
      e.s = s; e.n = ninst; e.nm = nm;
      q.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic alu(input logic [31:0] ir, input logic [3:0] ctl);
    instrucao = ir;
    cyc(0, 0, 1, 1, ex(3'd1, 6'b100100, pctl, 2'b00), "alu_fetch");
    cyc(0, 0, 0, 1, ex(3'd2, 6'b000000, pctl, 2'b00), "alu_decode");
    pctl = ctl;
    cyc(0, 0, 0, 1, ex(3'd3, 6'b000000, pctl, 2'b00), "alu_execute");
    cyc(0, 0, 0, 1, ex(3'd5, 6'b000011, pctl, 2'b00), "alu_writeback");
    ninst = (ninst + 1) & mask;
  endtask

  task automatic memop(input logic [31:0] ir, input logic is_st, input int nwait);
    instrucao = ir;
    cyc(0, 0, 1, 1, ex(3'd1, 6'b100100, pctl, 2'b00), "mem_fetch");
    cyc(0, 0, 0, 1, ex(3'd2, 6'b000000, pctl, 2'b00), "mem_decode");
    pctl = 4'b0100;
    cyc(0, 0, 0, 1, ex(3'd3, 6'b000000, pctl, 2'b00), "mem_execute");
    for (int i = 0; i < nwait; i++)
      cyc(0, 0, 0, 1, ex(3'd4, is_st ? 6'b111000 : 6'b101000, pctl, 2'b00), "mem_wait");
    if (is_st) begin
      cyc(0, 0, 1, 1, ex(3'd4, 6'b111010, pctl, 2'b00), "store_done");
      ninst = (ninst + 1) & mask;
    end else begin
      cyc(0, 0, 1, 1, ex(3'd4, 6'b101000, pctl, 2'b00), "load_done");
      cyc(0, 0, 0, 1, ex(3'd5, 6'b000011, pctl, 2'b00), "load_writeback");
      ninst = (ninst + 1) & mask;
    end
  endtask

  task automatic do_reset_idle(input string nm);
    cyc(1, 0, 0, 0, '0, "rst");
    ninst = 0; pctl = 4'b0000;
    cyc(0, 1, 0, 1, ex(3'd0, 6'b000000, 4'b0000, 2'b00), nm);
  endtask

  task automatic illegal(input logic [31:0] ir);
    instrucao = ir;
    cyc(0, 0, 1, 1, ex(3'd1, 6'b100100, pctl, 2'b00), "ill_fetch");
    cyc(0, 0, 0, 1, ex(3'd2, 6'b000000, pctl, 2'b00), "ill_decode");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 1, ex(3'd7, 6'b000000, pctl, 2'b01), "ill_trap_hold");
    do_reset_idle("ill_reset_idle");
  endtask

  initial begin
    cyc(1, 0, 0, 0, '0, "rst");
    cyc(1, 0, 0, 0, '0, "rst");
    cyc(0, 1, 1, 1, ex(3'd0, 6'b000000, 4'b0000, 2'b00), "reset_idle");

    alu(32'h002081B3, 4'b0111);   // add
    memop(32'h0000A103, 1'b0, 3); // load, 3 wait cycles
    memop(32'h0020A023, 1'b1, 0); // store, immediate ready
    alu(32'h40208133, 4'b0011);   // sub
    alu(32'h0020A113, 4'b1101);   // slti
    alu(32'h0000001F, 4'b0001);   // subi
    alu(32'h00108093, 4'b0101);   // addi
    illegal(32'h4020A133);        // R-type slt encoding with sub funct7
    illegal(32'hFFFFFFFF);

    // reset while a load waits in MEMORY
    alu(32'h002081B3, 4'b0111);
    instrucao = 32'h0000A103;
    cyc(0, 0, 1, 1, ex(3'd1, 6'b100100, pctl, 2'b00), "rm_fetch");
    cyc(0, 0, 0, 1, ex(3'd2, 6'b000000, pctl, 2'b00), "rm_decode");
    pctl = 4'b0100;
    cyc(0, 0, 0, 1, ex(3'd3, 6'b000000, pctl, 2'b00), "rm_execute");
    cyc(0, 0, 0, 1, ex(3'd4, 6'b101000, pctl, 2'b00), "rm_wait");
    cyc(0, 0, 0, 1, ex(3'd4, 6'b101000, pctl, 2'b00), "rm_wait");
    cyc(1, 0, 0, 0, '0, "rst");
    ninst = 0; pctl = 4'b0000;
    cyc(0, 0, 0, 1, ex(3'd0, 6'b000000, 4'b0000, 2'b00), "rm_idle");

    // TIMEOUT=2, COUNT_WIDTH=4 instance
    sel = 1'b1; mask = 32'hF;
    do_reset_idle("t2_idle");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, ex(3'd1, 6'b100000, pctl, 2'b00), "t2_fetch_wait");
    cyc(0, 0, 0, 1, ex(3'd7, 6'b000000, pctl, 2'b10), "t2_timeout_trap");
    do_reset_idle("t2_reset_idle");
    for (int i = 0; i < 2; i++)
      cyc(0, 0, 0, 1, ex(3'd1, 6'b100000, pctl, 2'b00), "t2_fetch_wait");
    for (int i = 0; i < 17; i++) alu(32'h002081B3, 4'b0111); // first fetch completes at the limit
    cyc(0, 0, 0, 1, ex(3'd1, 6'b100000, pctl, 2'b00), "t2_wrap");

    repeat (2) @(posedge clock);
    if (q.size() != 0) begin
      vecs++; miss++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multi-cycle sequencer for the processor datapath.
- Steps the datapath through IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP.
- Drives PC/IR enables, register-file write, memory request/write and ULA configuration (op_ula, ula_entry, operation_type) from the current state and the latched instruction.
- Handles memory wait states with a ready handshake and a timeout.
- Counts retired instructions.

Parameters:
- R_TYPE, 7'b0110011: opcode for register-register add/sub/slt.
- ARITMETIC_I, 7'b0010011: opcode for addi/slti.
- LOAD_TYPE, 7'b0000011: opcode for loads.
- STORE_TYPE, 7'b0100011: opcode for stores.
- SUBI, 7'b0011111: opcode for custom subtract-immediate.
- TIMEOUT, 15: maximum extra wait cycles for mem_ready. Range 0..255.
- COUNT_WIDTH, 32: width of instret.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  IDLE -> FETCH trigger.
- instrucao  in  32  current IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (store), 0 = read.
- addr_sel  out  1  0 = PC address, 1 = ULA result address.
- ir_en  out  1  IR load strobe.
- pc_en  out  1  PC <- PC+4 strobe.
- reg_we  out  1  register-file write enable.
- op_ula  out  2  00 = sub, 01 = add, 11 = slt.
- ula_entry  out  1  0 = immediate, 1 = rs2.
- operation_type  out  1  writeback source: 0 = memory, 1 = ULA.
- busy  out  1  state is not IDLE and not TRAP.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 = illegal instruction, 10 = memory timeout.
- instret  out  COUNT_WIDTH  retired-instruction counter.
- estado  out  3  state code: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, TRAP 7.

Behaviour:
- Reset (synchronous):
  - Next edge: state = IDLE.
  - All outputs 0, including instret, trap_cause and latched op_ula/ula_entry/operation_type.
  - Applies mid-operation; any outstanding request is dropped, with mem_req = 0 in the next cycle.
- IDLE: all strobes 0. start = 1 -> FETCH. start is ignored in every other state.
- FETCH:
  - Drives mem_req = 1, mem_we = 0, addr_sel = 0.
  - ir_en = mem_ready, combinational within this state.
  - On mem_ready -> DECODE.
- DECODE: classifies instrucao[6:0], [14:12] and [31:25], then latches the ULA controls:
  - R_TYPE:
    - funct3 000 with funct7 0000000 -> add (01).
    - funct3 000 with funct7 0100000 -> sub (00).
    - funct3 010 with funct7 0000000 -> slt (11).
    - ula_entry = 1, operation_type = 1.
  - ARITMETIC_I: funct3 000 -> 01, funct3 010 -> 11; ula_entry = 0, operation_type = 1.
  - LOAD_TYPE / STORE_TYPE: op_ula 01, ula_entry 0, operation_type 0.
  - SUBI: op_ula 00, ula_entry 0, operation_type 1.
  - Any other opcode/funct combination -> TRAP with cause 01; latched controls are unchanged.
  - Otherwise -> EXECUTE.
- Latched ULA controls hold until the next DECODE exit.
- EXECUTE: exactly one cycle, no strobes.
  - LOAD/STORE -> MEMORY.
  - Everything else -> WRITEBACK.
- MEMORY:
  - Drives mem_req = 1, addr_sel = 1; mem_we = 1 for STORE only.
  - On mem_ready, LOAD -> WRITEBACK.
  - On mem_ready, STORE asserts pc_en that cycle, increments instret, then -> FETCH.
- WRITEBACK: reg_we = 1 and pc_en = 1 for one cycle; instret increments; -> FETCH.
- Wait counter (8 bits):
  - Cleared on entry to FETCH or MEMORY; increments each cycle with mem_ready = 0.
  - mem_ready = 0 while counter == TIMEOUT -> TRAP with cause 10.
  - A request is therefore held at most TIMEOUT+1 cycles. With TIMEOUT = 0, a response is required in the first cycle.
- TRAP: trap = 1, all strobes 0, mem_req = 0. Only reset exits.
- instret wraps modulo 2^COUNT_WIDTH.
- Latency with zero-wait memory:
  - ALU instruction 4 cycles (F, D, E, W).
  - Load 5 cycles (F, D, E, M, W).
  - Store 4 cycles (F, D, E, M).
- reg_we and mem_we are never asserted in the same cycle. ir_en and pc_en are never asserted in the same cycle.

Test Plan:
- Reset, start = 1, IR = add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> estado sequence 1,2,3,5,1. op_ula = 01 and ula_entry = 1 from EXECUTE on; reg_we/pc_en pulse in WRITEBACK; instret = 1.
- Load 0x0000A103, mem_ready low 3 cycles in MEMORY -> mem_req/addr_sel held 4 cycles. WRITEBACK with operation_type = 0; total 8 cycles; instret +1.
- Store 0x0020A023, ready immediate -> mem_we = 1 in MEMORY only; pc_en in MEMORY; reg_we never 1; back to FETCH after 4 cycles.
- IR = 0xFFFFFFFF -> TRAP after DECODE with trap_cause = 01. Subsequent start/mem_ready have no effect until reset; then estado = 0 and instret = 0.
- TIMEOUT = 2, mem_ready = 0 in FETCH -> 3 request cycles, then TRAP with cause 10.
- Reset asserted in MEMORY mid-wait -> next cycle mem_req = 0, estado = 0, all outputs 0. COUNT_WIDTH = 4 with 17 retired instructions -> instret = 1.
